// File: rtl/adsr_envelope.sv
// Per-voice ADSR amplitude envelope: gate/tick driven level FSM and a
// registered sample scaler (sample_in * level >>> LEVEL_BITS).
module adsr_envelope #(
    parameter int unsigned LEVEL_BITS = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  gate,
    input  logic                  env_tick,
    input  logic [LEVEL_BITS-1:0] attack_step,
    input  logic [LEVEL_BITS-1:0] decay_step,
    input  logic [LEVEL_BITS-1:0] sustain_level,
    input  logic [LEVEL_BITS-1:0] release_step,
    input  logic signed [31:0]    sample_in,
    output logic signed [31:0]    sample_out,
    output logic [LEVEL_BITS-1:0] level,
    output logic [2:0]            state,
    output logic                  active
);

    localparam int unsigned PW = 32 + LEVEL_BITS + 1;
    localparam logic [LEVEL_BITS:0] FULL = {1'b0, {LEVEL_BITS{1'b1}}};

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StAttack  = 3'd1,
        StDecay   = 3'd2,
        StSustain = 3'd3,
        StRelease = 3'd4
    } state_e;

    state_e                state_q, state_d;
    logic [LEVEL_BITS-1:0] level_q, level_d;
    logic                  gate_q;
    logic                  rise, fall;
    logic [LEVEL_BITS:0]   attack_sum, decay_floor;
    logic signed [PW-1:0]  sample_ext, level_ext, product;
    logic                  unused_product_bits;

    assign rise        = gate & ~gate_q;
    assign fall        = ~gate & gate_q;
    assign attack_sum  = {1'b0, level_q} + {1'b0, attack_step};
    assign decay_floor = {1'b0, sustain_level} + {1'b0, decay_step};

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        if (rise) begin
            // Retrigger keeps the current level; no step on an edge cycle.
            state_d = StAttack;
        end else if (fall && (state_q == StAttack || state_q == StDecay ||
                              state_q == StSustain)) begin
            state_d = StRelease;
        end else if (env_tick) begin
            case (state_q)
                StIdle: level_d = '0;
                StAttack: begin
                    if (attack_sum >= FULL) begin
                        level_d = {LEVEL_BITS{1'b1}};
                        state_d = StDecay;
                    end else begin
                        level_d = attack_sum[LEVEL_BITS-1:0];
                    end
                end
                StDecay: begin
                    if ({1'b0, level_q} <= decay_floor) begin
                        level_d = sustain_level;
                        state_d = StSustain;
                    end else begin
                        level_d = level_q - decay_step;
                    end
                end
                StSustain: level_d = sustain_level;
                StRelease: begin
                    if (level_q <= release_step) begin
                        level_d = '0;
                        state_d = StIdle;
                    end else begin
                        level_d = level_q - release_step;
                    end
                end
                default: begin
                    state_d = StIdle;
                    level_d = '0;
                end
            endcase
        end
    end

    // Level is treated as unsigned, so it is zero-extended before the signed multiply.
    assign sample_ext = {{(PW-32){sample_in[31]}}, sample_in};
    assign level_ext  = {{(PW-LEVEL_BITS){1'b0}}, level_q};
    assign product    = sample_ext * level_ext;
    assign unused_product_bits = ^{product[PW-1], product[LEVEL_BITS-1:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            level_q    <= '0;
            gate_q     <= 1'b0;
            active     <= 1'b0;
            sample_out <= '0;
        end else begin
            state_q    <= state_d;
            level_q    <= level_d;
            gate_q     <= gate;
            active     <= (state_d != StIdle);
            sample_out <= product[LEVEL_BITS +: 32];
        end
    end

    assign level = level_q;
    assign state = state_q;

endmodule

// File: tb/tb_adsr_envelope.sv
// Directed bench for adsr_envelope: reset, full ADSR walk, scaling,
// edge-on-tick, retrigger, sustain tracking and zero-step stalls.
module tb_adsr_envelope;

    logic               clk;
    logic               reset;
    logic               gate;
    logic               env_tick;
    logic [15:0]        attack_step;
    logic [15:0]        decay_step;
    logic [15:0]        sustain_level;
    logic [15:0]        release_step;
    logic signed [31:0] sample_in;
    logic signed [31:0] sample_out;
    logic [15:0]        level;
    logic [2:0]         state;
    logic               active;

    int vectors;
    int miscompares;

    adsr_envelope #(.LEVEL_BITS(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .gate          (gate),
        .env_tick      (env_tick),
        .attack_step   (attack_step),
        .decay_step    (decay_step),
        .sustain_level (sustain_level),
        .release_step  (release_step),
        .sample_in     (sample_in),
        .sample_out    (sample_out),
        .level         (level),
        .state         (state),
        .active        (active)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock; outputs are inspected 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // One env_tick cycle followed by three quiet cycles is done by the callers.
    task automatic tick();
        env_tick = 1'b1;
        step();
        env_tick = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        gate = 1'b1;
        env_tick = 1'b0;
        sample_in = 32'sd1048576;
        idle(3);
        vectors++;
        if (state !== 3'd0 || level !== 16'h0 || sample_out !== 32'sd0 || active !== 1'b0) begin
            $display("FAIL reset: state=%0d level=%h out=%0d active=%b, want 0/0000/0/0",
                     state, level, sample_out, active);
            miscompares++;
        end
        reset = 1'b0;
        step();
        vectors++;
        if (state !== 3'd1 || level !== 16'h0 || active !== 1'b1) begin
            $display("FAIL reset_rise: state=%0d level=%h active=%b, want 1/0000/1",
                     state, level, active);
            miscompares++;
        end
    endtask

    task automatic test_full_adsr();
        logic [15:0] att_lv [4] = '{16'h4000, 16'h8000, 16'hC000, 16'hFFFF};
        logic [2:0]  att_st [4] = '{3'd1, 3'd1, 3'd1, 3'd2};
        logic [15:0] dec_lv [4] = '{16'hEFFF, 16'hDFFF, 16'hCFFF, 16'hC000};
        logic [2:0]  dec_st [4] = '{3'd2, 3'd2, 3'd2, 3'd3};
        logic [15:0] rel_lv [3] = '{16'h7000, 16'h2000, 16'h0000};
        logic [2:0]  rel_st [3] = '{3'd4, 3'd4, 3'd0};
        attack_step = 16'h4000;
        decay_step = 16'h1000;
        sustain_level = 16'hC000;
        release_step = 16'h5000;
        idle(2);
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if (level !== att_lv[i] || state !== att_st[i]) begin
                $display("FAIL attack[%0d]: level=%h state=%0d, want %h/%0d",
                         i, level, state, att_lv[i], att_st[i]);
                miscompares++;
            end
            idle(3);
        end
        sample_in = 32'sd1048576;
        step();
        vectors++;
        if (sample_out !== 32'sd1048560) begin
            $display("FAIL scale_full_pos: out=%0d, want 1048560", sample_out);
            miscompares++;
        end
        sample_in = -32'sd1048576;
        step();
        vectors++;
        if (sample_out !== -32'sd1048560) begin
            $display("FAIL scale_full_neg: out=%0d, want -1048560", sample_out);
            miscompares++;
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if (level !== dec_lv[i] || state !== dec_st[i]) begin
                $display("FAIL decay[%0d]: level=%h state=%0d, want %h/%0d",
                         i, level, state, dec_lv[i], dec_st[i]);
                miscompares++;
            end
            idle(3);
        end
        sample_in = 32'sd1048576;
        step();
        vectors++;
        if (sample_out !== 32'sd786432) begin
            $display("FAIL scale_sus_pos: out=%0d, want 786432", sample_out);
            miscompares++;
        end
        sample_in = -32'sd1048576;
        step();
        vectors++;
        if (sample_out !== -32'sd786432) begin
            $display("FAIL scale_sus_neg: out=%0d, want -786432", sample_out);
            miscompares++;
        end
        gate = 1'b0;
        step();
        vectors++;
        if (state !== 3'd4 || level !== 16'hC000) begin
            $display("FAIL gate_fall: state=%0d level=%h, want 4/c000", state, level);
            miscompares++;
        end
        idle(3);
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (level !== rel_lv[i] || state !== rel_st[i]) begin
                $display("FAIL release[%0d]: level=%h state=%0d, want %h/%0d",
                         i, level, state, rel_lv[i], rel_st[i]);
                miscompares++;
            end
            idle(3);
        end
        vectors++;
        if (active !== 1'b0 || sample_out !== 32'sd0) begin
            $display("FAIL idle_out: active=%b out=%0d, want 0/0", active, sample_out);
            miscompares++;
        end
    endtask

    task automatic test_edge_on_tick();
        logic [15:0] lv [7] = '{16'h4000, 16'h8000, 16'hC000, 16'hFFFF,
                                16'hEFFF, 16'hDFFF, 16'hCFFF};
        gate = 1'b1;
        tick();
        vectors++;
        if (state !== 3'd1 || level !== 16'h0000) begin
            $display("FAIL rise_on_tick: state=%0d level=%h, want 1/0000", state, level);
            miscompares++;
        end
        idle(3);
        for (int i = 0; i < 7; i++) begin
            tick();
            idle(3);
            vectors++;
            if (level !== lv[i]) begin
                $display("FAIL climb[%0d]: level=%h, want %h", i, level, lv[i]);
                miscompares++;
            end
        end
        tick();
        idle(3);
        gate = 1'b0;
        tick();
        vectors++;
        if (state !== 3'd4 || level !== 16'hC000) begin
            $display("FAIL fall_on_tick: state=%0d level=%h, want 4/c000", state, level);
            miscompares++;
        end
        idle(3);
    endtask

    task automatic test_retrigger();
        tick();
        idle(3);
        tick();
        idle(3);
        vectors++;
        if (state !== 3'd4 || level !== 16'h2000) begin
            $display("FAIL pre_retrig: state=%0d level=%h, want 4/2000", state, level);
            miscompares++;
        end
        gate = 1'b1;
        step();
        vectors++;
        if (state !== 3'd1 || level !== 16'h2000) begin
            $display("FAIL retrig: state=%0d level=%h, want 1/2000", state, level);
            miscompares++;
        end
        idle(2);
        tick();
        vectors++;
        if (level !== 16'h6000 || state !== 3'd1) begin
            $display("FAIL retrig_step: level=%h state=%0d, want 6000/1", level, state);
            miscompares++;
        end
        idle(3);
    endtask

    task automatic test_sustain_tracking();
        // 0x6000 -> A000 -> E000 -> FFFF, then four decay ticks to C000.
        for (int i = 0; i < 7; i++) begin
            tick();
            idle(3);
        end
        vectors++;
        if (state !== 3'd3 || level !== 16'hC000) begin
            $display("FAIL sus_reach: state=%0d level=%h, want 3/c000", state, level);
            miscompares++;
        end
        sustain_level = 16'h8000;
        step();
        tick();
        vectors++;
        if (state !== 3'd3 || level !== 16'h8000) begin
            $display("FAIL sus_track: state=%0d level=%h, want 3/8000", state, level);
            miscompares++;
        end
        idle(3);
    endtask

    task automatic test_stall();
        reset = 1'b1;
        gate = 1'b0;
        step();
        reset = 1'b0;
        attack_step = 16'h0000;
        gate = 1'b1;
        step();
        idle(3);
        for (int i = 0; i < 10; i++) begin
            tick();
            vectors++;
            if (level !== 16'h0000 || state !== 3'd1) begin
                $display("FAIL attack_stall[%0d]: level=%h state=%0d, want 0000/1",
                         i, level, state);
                miscompares++;
            end
            idle(3);
        end
        attack_step = 16'hFFFF;
        sustain_level = 16'hFFFF;
        tick();
        vectors++;
        if (level !== 16'hFFFF || state !== 3'd2) begin
            $display("FAIL attack_full: level=%h state=%0d, want ffff/2", level, state);
            miscompares++;
        end
        idle(3);
        tick();
        vectors++;
        if (level !== 16'hFFFF || state !== 3'd3) begin
            $display("FAIL sus_max: level=%h state=%0d, want ffff/3", level, state);
            miscompares++;
        end
        idle(3);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        reset = 1'b1;
        gate = 1'b0;
        env_tick = 1'b0;
        attack_step = '0;
        decay_step = '0;
        sustain_level = '0;
        release_step = '0;
        sample_in = '0;
        test_reset();
        test_full_adsr();
        test_edge_on_tick();
        test_retrigger();
        test_sustain_tracking();
        test_stall();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
